// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 pattern transmitter and its reference monitor.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   localparam logic [3:0] PATTERN = 4'b1011;
   localparam int         PAT_LEN = 4;

endpackage

// File: rtl/pattern_match_monitor.sv
// Watches a serial line and counts every overlapping occurrence of PATTERN (saturating).
module pattern_match_monitor
   import seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             clr_count,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count
);

   logic [PAT_LEN-2:0] hist;

   // bit_in is the value about to be registered onto the line, so the pulse lands with that bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist        <= '0;
         match_pulse <= 1'b0;
         match_count <= '0;
      end else begin
         hist        <= {hist[PAT_LEN-3:0], bit_in};
         match_pulse <= ({hist, bit_in} == PATTERN);
         if (clr_count)
            match_count <= '0;
         else if (match_pulse && (match_count != {CNT_W{1'b1}}))
            match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Parallel-to-serial MSB-first transmitter with optional inter-word gap and an embedded 1011 counter.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   input  logic             clr_count,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count
);

   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_t           state, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [BW-1:0]    bit_cnt, bit_next;
   logic [3:0]       gap_cnt, gap_next;
   logic             x_next, valid_next, load, hs;

   // A word is accepted on din_valid & din_ready; ready depends only on state and counters.
   always_comb begin
      din_ready = 1'b0;
      case (state)
         IDLE:    din_ready = 1'b1;
         SHIFT:   din_ready = (bit_cnt == '0) && (GAP_CYCLES == 0);
         GAP:     din_ready = (gap_cnt == '0);
         default: din_ready = 1'b0;
      endcase
   end

   assign hs = din_valid & din_ready;

   always_comb begin
      state_next = state;
      shift_next = shift_reg;
      bit_next   = bit_cnt;
      gap_next   = gap_cnt;
      x_next     = 1'b0;
      valid_next = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: load = hs;
         SHIFT: begin
            if (bit_cnt != '0) begin
               x_next     = shift_reg[WIDTH-1];
               valid_next = 1'b1;
               shift_next = {shift_reg[WIDTH-2:0], 1'b0};
               bit_next   = bit_cnt - BW'(1);
            end else if (GAP_CYCLES > 0) begin
               state_next = GAP;
               gap_next   = 4'(GAP_CYCLES - 1);
            end else if (hs) begin
               load = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt != '0)
               gap_next = gap_cnt - 4'd1;
            else if (hs)
               load = 1'b1;
            else
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Loading puts the MSB on the line next cycle and keeps the remaining bits left-aligned.
      if (load) begin
         state_next = SHIFT;
         x_next     = din[WIDTH-1];
         valid_next = 1'b1;
         shift_next = {din[WIDTH-2:0], 1'b0};
         bit_next   = BW'(WIDTH - 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         x_out     <= 1'b0;
         x_valid   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_cnt   <= bit_next;
         gap_cnt   <= gap_next;
         x_out     <= x_next;
         x_valid   <= valid_next;
         busy      <= (state_next != IDLE);
      end
   end

   pattern_match_monitor #(
      .CNT_W(CNT_W)
   ) u_monitor (
      .clk        (clk),
      .reset      (reset),
      .bit_in     (x_next),
      .clr_count  (clr_count),
      .match_pulse(match_pulse),
      .match_count(match_count)
   );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench: default config, a 2-bit counter config for saturation, and a GAP_CYCLES=2 config.
module tb_seq_pattern_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  din_a = '0, din_s = '0, din_g = '0;
   logic        valid_a = 0, valid_s = 0, valid_g = 0;
   logic        clr_a = 0, clr_s = 0, clr_g = 0;
   logic        ready_a, ready_s, ready_g;
   logic        x_a, x_s, x_g;
   logic        xv_a, xv_s, xv_g;
   logic        busy_a, busy_s, busy_g;
   logic        mp_a, mp_s, mp_g;
   logic [15:0] cnt_a, cnt_g;
   logic [1:0]  cnt_s;

   seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
      .x_out(x_a), .x_valid(xv_a), .busy(busy_a), .clr_count(clr_a),
      .match_pulse(mp_a), .match_count(cnt_a));

   seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(2)) dut_s (
      .clk(clk), .reset(rst), .din(din_s), .din_valid(valid_s), .din_ready(ready_s),
      .x_out(x_s), .x_valid(xv_s), .busy(busy_s), .clr_count(clr_s),
      .match_pulse(mp_s), .match_count(cnt_s));

   seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .CNT_W(16)) dut_g (
      .clk(clk), .reset(rst), .din(din_g), .din_valid(valid_g), .din_ready(ready_g),
      .x_out(x_g), .x_valid(xv_g), .busy(busy_g), .clr_count(clr_g),
      .match_pulse(mp_g), .match_count(cnt_g));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Handshake at the next rising edge (cycle 0); returns at the falling edge of cycle 1.
   task automatic push(input int which, input logic [7:0] w);
      @(negedge clk);
      case (which)
         0: begin din_a = w; valid_a = 1'b1; end
         1: begin din_s = w; valid_s = 1'b1; end
         default: begin din_g = w; valid_g = 1'b1; end
      endcase
      @(negedge clk);
      valid_a = 1'b0;
      valid_s = 1'b0;
      valid_g = 1'b0;
   endtask

   task automatic clear_a();
      @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_a", cnt_a, 0);
   endtask

   // Single word on dut_a; mask bit i = expected match_pulse in cycle i.
   task automatic tx_check_a(input string tag, input logic [7:0] w, input logic [8:0] mask);
      push(0, w);
      for (int i = 1; i <= 8; i++) begin
         check({tag, "_x"}, x_a, w[8-i]);
         check({tag, "_xv"}, xv_a, 1);
         check({tag, "_mp"}, mp_a, mask[i]);
         @(negedge clk);
      end
      check({tag, "_idle_busy"}, busy_a, 0);
      check({tag, "_idle_xv"}, xv_a, 0);
      check({tag, "_idle_rdy"}, ready_a, 1);
   endtask

   initial begin
      logic [7:0] w;
      logic       xv_exp;
      logic       x_exp;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rdy", ready_a, 1);
      check("rst_x", x_a, 0);
      check("rst_xv", xv_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_mp", mp_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_cnt_s", cnt_s, 0);
      check("rst_rdy_g", ready_g, 1);

      // Test 1: reset mid-word after three bits of 8'hFF
      push(0, 8'hFF);
      for (int i = 1; i <= 3; i++) begin
         check("t1_x", x_a, 1);
         check("t1_busy", busy_a, 1);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("t1_rst_x", x_a, 0);
      check("t1_rst_xv", xv_a, 0);
      check("t1_rst_busy", busy_a, 0);
      check("t1_rst_cnt", cnt_a, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t1_rdy", ready_a, 1);
      @(negedge clk);
      check("t1_no_tail_xv", xv_a, 0);
      check("t1_no_tail_x", x_a, 0);

      // Test 2: single word, one match in cycle 4
      tx_check_a("t2", 8'b1011_0000, 9'b0_0001_0000);
      check("t2_cnt", cnt_a, 1);

      // Test 3: overlapping matches in cycles 4 and 7
      clear_a();
      tx_check_a("t3", 8'b1011_0110, 9'b0_1001_0000);
      check("t3_cnt", cnt_a, 2);

      // Test 4: back-to-back words, din changes outside handshake ignored
      clear_a();
      @(negedge clk);
      din_a = 8'h05;
      valid_a = 1'b1;
      @(negedge clk);
      din_a = 8'h80;
      for (int i = 1; i <= 16; i++) begin
         w = (i <= 8) ? 8'h05 : 8'h80;
         if (i == 9) valid_a = 1'b0;
         check("t4_x", x_a, w[7 - ((i - 1) % 8)]);
         check("t4_xv", xv_a, 1);
         check("t4_rdy", ready_a, (i == 8) || (i == 16));
         check("t4_mp", mp_a, i == 9);
         @(negedge clk);
      end
      check("t4_idle_busy", busy_a, 0);
      check("t4_idle_xv", xv_a, 0);
      check("t4_cnt", cnt_a, 1);

      // Test 5: saturation at 3, then clear coincident with a match pulse
      push(1, 8'b1011_0110);
      repeat (8) @(negedge clk);
      check("t5_cnt2", cnt_s, 2);
      push(1, 8'b1011_0110);
      repeat (8) @(negedge clk);
      check("t5_sat", cnt_s, 3);
      push(1, 8'b1011_0000);
      repeat (3) @(negedge clk);
      check("t5_mp", mp_s, 1);
      clr_s = 1'b1;
      @(negedge clk);
      clr_s = 1'b0;
      check("t5_clr", cnt_s, 0);
      repeat (4) @(negedge clk);
      check("t5_clr_hold", cnt_s, 0);

      // Test 6: two-cycle gap, ready only in the final gap cycle, gap zeros break the pattern
      @(negedge clk);
      din_g = 8'b0000_0010;
      valid_g = 1'b1;
      @(negedge clk);
      din_g = 8'b1100_0000;
      for (int i = 1; i <= 20; i++) begin
         if (i == 11) valid_g = 1'b0;
         xv_exp = (i <= 8) || (i >= 11 && i <= 18);
         w = (i <= 8) ? 8'b0000_0010 : 8'b1100_0000;
         x_exp = (i <= 8) ? w[8-i] : ((i >= 11 && i <= 18) ? w[18-i] : 1'b0);
         check("t6_xv", xv_g, xv_exp);
         check("t6_x", x_g, x_exp);
         check("t6_rdy", ready_g, (i == 10) || (i == 20));
         check("t6_busy", busy_g, 1);
         check("t6_mp", mp_g, 0);
         @(negedge clk);
      end
      check("t6_idle_busy", busy_g, 0);
      check("t6_idle_rdy", ready_g, 1);
      check("t6_cnt", cnt_g, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-stream transmitter for the sequence-detector path. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a single-bit serial line that feeds the 1011 detector's x input.
- An embedded reference monitor counts every overlapping 1011 occurrence on the transmitted line. Verification compares this count against the detector's y pulses.

Parameters:
- WIDTH, 8, word width in bits (legal 2..32)
- GAP_CYCLES, 0, idle cycles inserted after each word (legal 0..15)
- CNT_W, 16, width of the match counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- din  in  WIDTH  parallel word to transmit
- din_valid  in  1  din is valid
- din_ready  out  1  block can accept din this cycle
- x_out  out  1  serial bit; 0 whenever x_valid=0
- x_valid  out  1  x_out carries a data bit
- busy  out  1  state != IDLE
- clr_count  in  1  synchronous clear of match_count
- match_pulse  out  1  high in the same cycle x_out completes 1011
- match_count  out  CNT_W  saturating count of 1011 occurrences

Behaviour:
- Reset (async, active-high) sets: state=IDLE, shift reg=0, bit counter=0, gap counter=0, x_out=0, x_valid=0, match history=000, match_count=0, match_pulse=0. din_ready=1 as soon as reset is released. Reset mid-word discards the word with no partial output afterwards.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: din_ready=1. A handshake (din_valid & din_ready) at edge k loads the shift reg and sets bit_cnt=WIDTH-1. The block goes to SHIFT, and x_out=din[WIDTH-1] with x_valid=1 during cycle k+1. Latency is 1 cycle.
- SHIFT: one bit per cycle MSB-first, x_valid=1. At the last bit (bit_cnt=0):
  - if GAP_CYCLES>0, go to GAP;
  - else din_ready=1 in that cycle. A handshake then loads the next word with no bubble (x_valid stays high). Without a handshake, go to IDLE.
- GAP: x_valid=0, x_out=0 for exactly GAP_CYCLES cycles. din_ready=1 only in the final gap cycle; a handshake there goes to SHIFT, otherwise the block goes to IDLE.
- din is sampled only at a handshake. Changes to din outside a handshake are ignored.
- din_ready is combinational from state/counters only. It never depends on din_valid.
- All outputs except din_ready are registered.
- Match monitor:
  - hist[2:0] shifts in x_out every cycle, including idle/gap zeros. This matches a detector that has no valid qualifier.
  - match_pulse = ({hist, x_out} == 4'b1011), registered to align with x_out.
  - Overlapping matches count; the trailing "1" of a match may start the next match.
  - The history persists across word boundaries and gaps.
- The downstream Moore detector asserts y one cycle after match_pulse.
- match_count: +1 per match_pulse; saturates at all-ones with no wrap. clr_count has priority over a simultaneous increment, so the result is 0.

Decomposition:
- Package seq_pkg:
  - state enum (IDLE, SHIFT, GAP);
  - PATTERN=4'b1011;
  - PAT_LEN=4.
- Sub-module pattern_match_monitor (hist, match_pulse, saturating counter) is natural to split out. It is reusable as a standalone bench checker.

Test Plan:
1. Reset mid-word (reset after 3 bits of 8'hFF) -> x_out=0, x_valid=0, busy=0, din_ready=1, match_count=0. The next word transmits cleanly from its MSB.
2. Single word 8'b1011_0000, GAP=0, handshake at cycle 0 -> x_out=1,0,1,1,0,0,0,0 in cycles 1-8. match_pulse only in cycle 4; match_count=1; IDLE at cycle 9.
3. Overlap: word 8'b1011_0110 -> match_pulse in cycles 4 and 7; match_count=2.
4. Back-to-back: 8'b0000_0101 then 8'b1000_0000 with din_valid held, GAP=0 -> din_ready=1 in cycle 8 and x_valid high for cycles 1-16 continuously. A cross-boundary match gives match_pulse in cycle 9.
5. Saturation and clear: CNT_W=2, four matches -> match_count stays 3. clr_count coincident with a match_pulse -> match_count=0 the next cycle.
6. Gap: GAP_CYCLES=2, words 8'b0000_0010 then 8'b1100_0000 -> x_valid low in cycles 9-10, x_out=0 during the gap, din_ready high only in cycle 10. The gap zeros break the pattern, so there is no match_pulse.
